// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to Memory on the X/Y/Z
// strobe frame, and captures one instruction per frame unless stalled or redirected.
module fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cyclex,
  input  logic              cycley,
  input  logic              cyclez,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {
    WAIT_X,
    WAIT_Y,
    WAIT_Z
  } state_t;

  localparam logic [ADDR_W-1:0] PC_INC = 1;

  state_t            state;
  logic              pending;
  logic [ADDR_W-1:0] target;
  logic              take_branch;
  logic [ADDR_W-1:0] redirect_pc;

  // A branch arriving on the resolving cyclez edge still redirects that frame.
  assign take_branch = pending | branch_valid;
  assign redirect_pc = branch_valid ? branch_target : target;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= WAIT_X;
      pc          <= RESET_PC;
      mem_raddr   <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      pending     <= 1'b0;
      target      <= '0;
    end else begin
      instr_valid <= 1'b0;
      if (branch_valid) begin
        pending <= 1'b1;
        target  <= branch_target;
      end
      case (state)
        WAIT_X: begin
          if (cyclex) begin
            mem_raddr <= pc;
            state     <= WAIT_Y;
          end
        end
        WAIT_Y: begin
          if (cycley) state <= WAIT_Z;
        end
        WAIT_Z: begin
          if (cyclez) begin
            state <= WAIT_X;
            // Redirect squashes the capture and takes priority over stall.
            if (take_branch) begin
              pc      <= redirect_pc;
              pending <= 1'b0;
            end else if (!stall) begin
              instr       <= mem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + PC_INC;
            end
          end
        end
        default: state <= WAIT_X;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory model returns 16'hA000 ^ address.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyclex = 1'b0, cycley = 1'b0, cyclez = 1'b0;
  logic        stall = 1'b0;
  logic        branch_valid = 1'b0;
  logic [15:0] branch_target = '0;
  logic [15:0] mem_rdata;
  logic [15:0] mem_raddr, instr, instr_pc, pc;
  logic        instr_valid;
  int          errors = 0;
  int          checks = 0;

  fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .cyclex(cyclex), .cycley(cycley), .cyclez(cyclez),
    .stall(stall), .branch_valid(branch_valid), .branch_target(branch_target),
    .mem_rdata(mem_rdata), .mem_raddr(mem_raddr), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .pc(pc)
  );

  always #5 clk = ~clk;

  assign mem_rdata = 16'hA000 ^ mem_raddr;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input logic x, input logic y, input logic z);
    cyclex = x; cycley = y; cyclez = z;
    @(negedge clk);
    cyclex = 1'b0; cycley = 1'b0; cyclez = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; stall = 1'b0; branch_valid = 1'b0;
    step(0, 0, 0); step(0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic clean_frame();
    step(1, 0, 0); step(0, 1, 0); step(0, 0, 1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    apply_reset();
    checks++; if (pc !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pc got=%h exp=0000", pc); end
    checks++; if (mem_raddr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_raddr got=%h exp=0000", mem_raddr); end
    checks++; if (instr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_instr got=%h exp=0000", instr); end
    checks++; if (instr_pc !== 16'h0000) begin errors++; $display("[TB] FAIL reset_instr_pc got=%h exp=0000", instr_pc); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", instr_valid); end
  endtask

  task automatic test_sequential();
    logic [15:0] exp_instr [4] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      checks++; if (mem_raddr !== 16'(i)) begin errors++; $display("[TB] FAIL seq_raddr%0d got=%h exp=%h", i, mem_raddr, 16'(i)); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_valid_low_x%0d got=%b exp=0", i, instr_valid); end
      step(0, 1, 0);
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_valid_low_y%0d got=%b exp=0", i, instr_valid); end
      step(0, 0, 1);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid%0d got=%b exp=1", i, instr_valid); end
      checks++; if (instr !== exp_instr[i]) begin errors++; $display("[TB] FAIL seq_instr%0d got=%h exp=%h", i, instr, exp_instr[i]); end
      checks++; if (instr_pc !== 16'(i)) begin errors++; $display("[TB] FAIL seq_instr_pc%0d got=%h exp=%h", i, instr_pc, 16'(i)); end
    end
    checks++; if (pc !== 16'h0004) begin errors++; $display("[TB] FAIL seq_final_pc got=%h exp=0004", pc); end
  endtask

  task automatic test_stall();
    apply_reset();
    clean_frame();
    stall = 1'b1;
    clean_frame();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_pulse got=%b exp=0", instr_valid); end
    checks++; if (pc !== 16'h0001) begin errors++; $display("[TB] FAIL stall_pc_held got=%h exp=0001", pc); end
    stall = 1'b0;
    step(1, 0, 0);
    checks++; if (mem_raddr !== 16'h0001) begin errors++; $display("[TB] FAIL stall_refetch_raddr got=%h exp=0001", mem_raddr); end
    step(0, 1, 0); step(0, 0, 1);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_resume_valid got=%b exp=1", instr_valid); end
    checks++; if (instr !== 16'hA001) begin errors++; $display("[TB] FAIL stall_resume_instr got=%h exp=A001", instr); end
    checks++; if (pc !== 16'h0002) begin errors++; $display("[TB] FAIL stall_resume_pc got=%h exp=0002", pc); end
  endtask

  task automatic test_branch();
    apply_reset();
    clean_frame(); clean_frame();
    step(1, 0, 0);
    checks++; if (mem_raddr !== 16'h0002) begin errors++; $display("[TB] FAIL br_raddr2 got=%h exp=0002", mem_raddr); end
    branch_valid = 1'b1; branch_target = 16'h0040;
    step(0, 1, 0);
    branch_valid = 1'b0; branch_target = 16'h0000;
    step(0, 0, 1);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL br_squash got=%b exp=0", instr_valid); end
    checks++; if (pc !== 16'h0040) begin errors++; $display("[TB] FAIL br_pc got=%h exp=0040", pc); end
    step(1, 0, 0);
    checks++; if (mem_raddr !== 16'h0040) begin errors++; $display("[TB] FAIL br_raddr got=%h exp=0040", mem_raddr); end
    step(0, 1, 0); step(0, 0, 1);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL br_target_valid got=%b exp=1", instr_valid); end
    checks++; if (instr_pc !== 16'h0040) begin errors++; $display("[TB] FAIL br_instr_pc got=%h exp=0040", instr_pc); end
    checks++; if (instr !== 16'hA040) begin errors++; $display("[TB] FAIL br_instr got=%h exp=A040", instr); end
    checks++; if (pc !== 16'h0041) begin errors++; $display("[TB] FAIL br_next_pc got=%h exp=0041", pc); end
  endtask

  task automatic test_branch_beats_stall();
    apply_reset();
    stall = 1'b1;
    step(1, 0, 0); step(0, 1, 0);
    branch_valid = 1'b1; branch_target = 16'h0100;
    step(0, 0, 1);
    branch_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL bs_no_pulse got=%b exp=0", instr_valid); end
    checks++; if (pc !== 16'h0100) begin errors++; $display("[TB] FAIL bs_pc got=%h exp=0100", pc); end
    clean_frame();
    checks++; if (pc !== 16'h0100) begin errors++; $display("[TB] FAIL bs_stall_hold got=%h exp=0100", pc); end
    stall = 1'b0;
    step(1, 0, 0);
    checks++; if (mem_raddr !== 16'h0100) begin errors++; $display("[TB] FAIL bs_raddr got=%h exp=0100", mem_raddr); end
    step(0, 1, 0); step(0, 0, 1);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL bs_valid got=%b exp=1", instr_valid); end
    checks++; if (instr !== 16'hA100) begin errors++; $display("[TB] FAIL bs_instr got=%h exp=A100", instr); end
  endtask

  task automatic test_wrap();
    apply_reset();
    branch_valid = 1'b1; branch_target = 16'h1234;
    step(0, 0, 0);
    branch_target = 16'hFFFF;
    step(0, 0, 0);
    branch_valid = 1'b0; branch_target = 16'h0000;
    clean_frame();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_squash got=%b exp=0", instr_valid); end
    checks++; if (pc !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_last_wins got=%h exp=FFFF", pc); end
    clean_frame();
    checks++; if (instr_pc !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_instr_pc got=%h exp=FFFF", instr_pc); end
    checks++; if (instr !== 16'h5FFF) begin errors++; $display("[TB] FAIL wrap_instr got=%h exp=5FFF", instr); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_pc got=%h exp=0000", pc); end
    clean_frame();
    checks++; if (instr_pc !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_pending_cleared got=%h exp=0000", instr_pc); end
  endtask

  task automatic test_strobe_order();
    apply_reset();
    clean_frame();
    step(0, 0, 1); step(0, 1, 0);
    checks++; if (mem_raddr !== 16'h0000) begin errors++; $display("[TB] FAIL ord_ignore_raddr got=%h exp=0000", mem_raddr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL ord_ignore_valid got=%b exp=0", instr_valid); end
    step(1, 1, 1);
    checks++; if (mem_raddr !== 16'h0001) begin errors++; $display("[TB] FAIL ord_multi_x got=%h exp=0001", mem_raddr); end
    step(0, 0, 1);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL ord_early_z got=%b exp=0", instr_valid); end
    step(0, 1, 1);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL ord_multi_y got=%b exp=0", instr_valid); end
    step(0, 0, 1);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL ord_final_valid got=%b exp=1", instr_valid); end
    checks++; if (instr_pc !== 16'h0001) begin errors++; $display("[TB] FAIL ord_instr_pc got=%h exp=0001", instr_pc); end
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    clean_frame();
    step(1, 0, 0); step(0, 1, 0);
    rst_n = 1'b0;
    step(0, 0, 1);
    rst_n = 1'b1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid got=%b exp=0", instr_valid); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("[TB] FAIL mid_pc got=%h exp=0000", pc); end
    checks++; if (mem_raddr !== 16'h0000) begin errors++; $display("[TB] FAIL mid_raddr got=%h exp=0000", mem_raddr); end
    checks++; if (instr !== 16'h0000) begin errors++; $display("[TB] FAIL mid_instr got=%h exp=0000", instr); end
    checks++; if (instr_pc !== 16'h0000) begin errors++; $display("[TB] FAIL mid_instr_pc got=%h exp=0000", instr_pc); end
    step(0, 0, 1);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_late_pulse got=%b exp=0", instr_valid); end
    step(1, 0, 0);
    checks++; if (mem_raddr !== 16'h0000) begin errors++; $display("[TB] FAIL mid_restart_raddr got=%h exp=0000", mem_raddr); end
    step(0, 1, 0); step(0, 0, 1);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin errors++; $display("[TB] FAIL mid_restart_fetch got=%b/%h exp=1/0000", instr_valid, instr_pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_beats_stall();
    test_wrap();
    test_strobe_order();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
